// File: rtl/gfau_ctrl_if.sv
// gfau_ctrl_if: bundles every non-clock signal of the GFAU controller.
//   cmd_*      : command handshake (valid/ready) plus opcode and register indices
//   wr_*/rd_*  : host register-file write port and combinational read port
//   gf_*       : operands/opcode/start towards the GFAU, result/done back from it
//   busy, cmd_done, error, err_clr : status and sticky-error clear
// modport slave  : the controller side
// modport master : the host/GFAU side (testbench)
interface gfau_ctrl_if #(
    parameter int SIZE = 32,
    parameter int AW   = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_src0;
    logic [AW-1:0]   cmd_src1;
    logic [AW-1:0]   cmd_dst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [SIZE-1:0] wr_data;
    logic [AW-1:0]   rd_addr;
    logic [SIZE-1:0] rd_data;
    logic [SIZE-1:0] gf_in_0;
    logic [SIZE-1:0] gf_in_1;
    logic [1:0]      gf_op;
    logic            gf_start;
    logic [SIZE-1:0] gf_result;
    logic            gf_done;
    logic            busy;
    logic            cmd_done;
    logic            error;
    logic            err_clr;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst,
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  gf_result, gf_done, err_clr,
        output cmd_ready, rd_data, gf_in_0, gf_in_1, gf_op, gf_start,
        output busy, cmd_done, error
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst,
        output wr_en, wr_addr, wr_data, rd_addr,
        output gf_result, gf_done, err_clr,
        input  cmd_ready, rd_data, gf_in_0, gf_in_1, gf_op, gf_start,
        input  busy, cmd_done, error
    );
endinterface

// File: rtl/gfau_ctrl.sv
// gfau_ctrl: sequences one GFAU operation per command. Holds an NREG x SIZE
// register file, latches the two source operands and opcode on command
// accept, pulses gf_start for one cycle, waits (bounded by TIMEOUT) for
// gf_done, then writes the captured result back to the destination register.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active low
//   bus   : gfau_ctrl_if.slave (handshake, register port, GFAU link, status)
module gfau_ctrl #(
    parameter int SIZE    = 32,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst,
    gfau_ctrl_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    state_t          state, state_nx;
    logic            accept, capture, expire;
    logic [SIZE-1:0] regs [NREG];
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   dst;
    logic [SIZE-1:0] res;

    // Ready is also held low while reset is asserted so every output reads 0.
    assign bus.cmd_ready = (state == IDLE) && i_rst;
    assign bus.busy      = (state != IDLE);
    assign bus.gf_start  = (state == ISSUE);
    assign bus.rd_data   = regs[bus.rd_addr];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                // A done arriving on the last allowed cycle still counts.
                if (bus.gf_done) begin
                    capture  = 1'b1;
                    state_nx = WRITE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    expire   = 1'b1;
                    state_nx = IDLE;
                end
            end
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Host writes only land in IDLE; result write-back only in WRITE, so the
    // two ports never collide.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == IDLE && bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end else if (state == WRITE) begin
            regs[dst] <= res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bus.gf_in_0  <= '0;
            bus.gf_in_1  <= '0;
            bus.gf_op    <= '0;
            bus.cmd_done <= 1'b0;
            bus.error    <= 1'b0;
            dst          <= '0;
            res          <= '0;
            cnt          <= '0;
        end else begin
            // Registered so the pulse lands in WRITE, or in the IDLE cycle
            // right after a timeout.
            bus.cmd_done <= capture | expire;
            // Operands read the pre-write register values when a host write
            // coincides with accept (non-blocking read of regs).
            if (accept) begin
                bus.gf_in_0 <= regs[bus.cmd_src0];
                bus.gf_in_1 <= regs[bus.cmd_src1];
                bus.gf_op   <= bus.cmd_op;
                dst         <= bus.cmd_dst;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (capture) res <= bus.gf_result;
            if (expire)           bus.error <= 1'b1;
            else if (bus.err_clr) bus.error <= 1'b0;
        end
    end
endmodule

// File: doc/gfau_ctrl.md
GFAU_CTRL -- requirements
Module: gfau_ctrl

Interface
REQ-001 SHALL have parameters: SIZE, 32, operand width; NREG, 8, register-file depth; TIMEOUT, 1023, max WAIT cycles before abort.
REQ-002 SHALL have ports: i_clk  in  1  clock, rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid in 1, cmd_ready out 1: command handshake, accepted on the rising edge where both are 1.
REQ-005 cmd_op in 2 (0 add, 1 sub, 2 mult, 3 div); cmd_src0, cmd_src1, cmd_dst in 3: register indices.
REQ-006 wr_en in 1, wr_addr in 3, wr_data in SIZE: host register write; rd_addr in 3, rd_data out SIZE: host read.
REQ-007 gf_in_0, gf_in_1 out SIZE; gf_op out 2; gf_start out 1: drive the GFAU in_0, in_1, operation_select and done_from_control inputs.
REQ-008 gf_result in SIZE, gf_done in 1: driven by the GFAU result and done_to_control outputs.
REQ-009 busy out 1; cmd_done out 1 (one-cycle pulse); error out 1 (sticky); err_clr in 1.

Function
REQ-010 SHALL contain NREG x SIZE register file; rd_data = reg[rd_addr] combinationally.
REQ-011 FSM states: IDLE, ISSUE, WAIT, WRITE.
REQ-012 IDLE: cmd_ready=1, busy=0; on accept, latch gf_in_0=reg[src0], gf_in_1=reg[src1], gf_op=cmd_op, dst=cmd_dst; go to ISSUE.
REQ-013 ISSUE: gf_start=1 for exactly this one cycle, clear wait counter, go to WAIT.
REQ-014 WAIT: gf_start=0; counter increments each cycle; the first cycle with gf_done=1 captures gf_result, then goes to WRITE.
REQ-015 WAIT: if counter reaches TIMEOUT without gf_done, set error=1, pulse cmd_done, skip the write, return to IDLE.
REQ-016 WRITE: reg[dst]=captured result, cmd_done=1 for this cycle, go to IDLE.
REQ-017 gf_in_0, gf_in_1 and gf_op SHALL stay stable from ISSUE until leaving WAIT; the datapath samples operands on every iteration.
REQ-018 cmd_ready=0 and busy=1 in ISSUE, WAIT and WRITE; the next command can be accepted in the cycle after WRITE.
REQ-019 Latency: accept edge E; gf_start in cycle E+1; if the GFAU asserts gf_done k cycles after gf_start, cmd_done is in cycle E+2+k.
REQ-020 gf_done in IDLE, ISSUE or WRITE SHALL be ignored; only the first gf_done in WAIT counts.
REQ-021 wr_en is honoured only in IDLE; ignored otherwise.
REQ-022 Simultaneous wr_en and accept in IDLE: operands latch pre-write values; the write completes.
REQ-023 src0==src1 and dst equal to either source are legal; dst is written only in WRITE.
REQ-024 error clears on err_clr=1 at any state; if timeout and err_clr occur in the same cycle, set wins.
REQ-025 No arithmetic on data; the controller only transports values; the counter is wide enough for TIMEOUT, no wrap.

Reset
REQ-026 i_rst=0 asynchronously forces: state IDLE, all registers 0, gf_in_0=gf_in_1=0, gf_op=0, gf_start=0, cmd_done=0, error=0, busy=0, counter 0.
REQ-027 Reset mid-operation SHALL abort with no register write and no cmd_done; cmd_ready=1 in the first cycle after release.

Verification (bench uses a behavioural GFAU responder with programmable latency)
REQ-028 Reset: assert i_rst=0 mid-cycle -> all outputs 0 immediately, cmd_ready=1 after release.
REQ-029 Load reg1=20, reg2=5; cmd add src0=1 src1=2 dst=3; responder returns 0x2 after k=2 -> gf_start high one cycle, gf_in_0=20 and gf_in_1=5 held throughout, cmd_done at E+4, reg3=2.
REQ-030 cmd_valid held high with two commands, responder k=33 -> second accepted in the cycle after first cmd_done; gf_start pulses twice, 36 cycles apart.
REQ-031 Responder silent -> error=1 and cmd_done pulse after TIMEOUT WAIT cycles, dst unchanged; err_clr -> error=0.
REQ-032 gf_done pulsed in IDLE, and twice in WAIT with values 7 then 9 -> IDLE pulse ignored, dst=7.
REQ-033 i_rst=0 during WAIT, then wr_en during busy on a later command -> no write from the aborted command, wr_en ignored, reg contents unchanged.
